ex_mem_stage: RTL and testbench



---
 rtl/ex_mem_stage_pkg.sv | 69 ++++++
 rtl/ex_mem_stage_if.sv | 37 +++
 rtl/ex_mem_stage_alu.sv | 28 ++
 rtl/ex_mem_stage.sv | 88 ++++++++
 tb/tb_ex_mem_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared encodings for the MIPS execute stage: I-type ALUop selectors, R-type
// function codes, the internal ALU control enum and the EX/MEM register layout.
package ex_mem_stage_pkg;

   localparam logic [2:0] ALUOP_ADD = 3'b000;
   localparam logic [2:0] ALUOP_SUB = 3'b001;
   localparam logic [2:0] ALUOP_OR  = 3'b010;
   localparam logic [2:0] ALUOP_AND = 3'b011;
   localparam logic [2:0] ALUOP_SLT = 3'b100;

   localparam logic [5:0] FUNC_ADD  = 6'b100000;
   localparam logic [5:0] FUNC_SUB  = 6'b100010;
   localparam logic [5:0] FUNC_AND  = 6'b100100;
   localparam logic [5:0] FUNC_OR   = 6'b100101;
   localparam logic [5:0] FUNC_SLT  = 6'b101010;
   localparam logic [5:0] FUNC_SLTU = 6'b101011;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_SLTU
   } alu_ctrl_e;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] jtarg;
      logic [31:0] btarg;
      logic [31:0] alu_out;
      logic [31:0] bus_b;
      logic [4:0]  rw;
      logic        zero;
      logic        reg_wr;
      logic        mem_to_reg;
      logic        mem_wr;
      logic        branch;
      logic        jump;
   } ex_mem_t;

   // Unknown func or ALUop codes fall back to ADD.
   function automatic alu_ctrl_e alu_decode(input logic       r_type,
                                            input logic [5:0] func,
                                            input logic [2:0] aluop);
      alu_ctrl_e ctrl;
      ctrl = ALU_ADD;
      if (r_type) begin
         case (func)
            FUNC_SUB:  ctrl = ALU_SUB;
            FUNC_AND:  ctrl = ALU_AND;
            FUNC_OR:   ctrl = ALU_OR;
            FUNC_SLT:  ctrl = ALU_SLT;
            FUNC_SLTU: ctrl = ALU_SLTU;
            default:   ctrl = ALU_ADD;
         endcase
      end else begin
         case (aluop)
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_OR:  ctrl = ALU_OR;
            ALUOP_AND: ctrl = ALU_AND;
            ALUOP_SLT: ctrl = ALU_SLT;
            default:   ctrl = ALU_ADD;
         endcase
      end
      return ctrl;
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX inputs, MEM/WB forwarding sources and EX/MEM outputs of the execute stage.
interface ex_mem_stage_if;

   logic [31:0] EX_PC4, EX_Jtarg, EX_busA, EX_busB;
   logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
   logic [5:0]  EX_func;
   logic [15:0] EX_immd;
   logic [2:0]  EX_ALUop;
   logic        EX_RegWr, EX_ALUSrc, EX_RegDst, EX_MemtoReg, EX_MemWr;
   logic        EX_Branch, EX_Jump, EX_ExtOp, EX_R_type;
   logic        MEM_PCSrc;
   logic        WB_RegWr;
   logic [4:0]  WB_Rw;
   logic [31:0] WB_busW;
   logic [31:0] MEM_PC4, MEM_Jtarg, MEM_Btarg, MEM_ALUout, MEM_busB;
   logic [4:0]  MEM_Rw;
   logic        MEM_Zero, MEM_RegWr, MEM_MemtoReg, MEM_MemWr, MEM_Branch, MEM_Jump;

   modport master (
      output EX_PC4, EX_Jtarg, EX_busA, EX_busB, EX_Rs, EX_Rt, EX_Rd, EX_func,
             EX_immd, EX_ALUop, EX_RegWr, EX_ALUSrc, EX_RegDst, EX_MemtoReg,
             EX_MemWr, EX_Branch, EX_Jump, EX_ExtOp, EX_R_type, MEM_PCSrc,
             WB_RegWr, WB_Rw, WB_busW,
      input  MEM_PC4, MEM_Jtarg, MEM_Btarg, MEM_ALUout, MEM_busB, MEM_Rw,
             MEM_Zero, MEM_RegWr, MEM_MemtoReg, MEM_MemWr, MEM_Branch, MEM_Jump
   );

   modport slave (
      input  EX_PC4, EX_Jtarg, EX_busA, EX_busB, EX_Rs, EX_Rt, EX_Rd, EX_func,
             EX_immd, EX_ALUop, EX_RegWr, EX_ALUSrc, EX_RegDst, EX_MemtoReg,
             EX_MemWr, EX_Branch, EX_Jump, EX_ExtOp, EX_R_type, MEM_PCSrc,
             WB_RegWr, WB_Rw, WB_busW,
      output MEM_PC4, MEM_Jtarg, MEM_Btarg, MEM_ALUout, MEM_busB, MEM_Rw,
             MEM_Zero, MEM_RegWr, MEM_MemtoReg, MEM_MemWr, MEM_Branch, MEM_Jump
   );

endinterface

// File: rtl/ex_mem_stage_alu.sv
// Combinational 32-bit ALU: add/sub wrap, bitwise and/or, signed/unsigned set-less-than.
module ex_mem_stage_alu
   import ex_mem_stage_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  alu_ctrl_e   i_ctrl,
   output logic [31:0] o_result,
   output logic        o_zero
);

   // NOTE: o_result gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      o_result = '0;
      case (i_ctrl)
         ALU_ADD:  o_result = i_a + i_b;
         ALU_SUB:  o_result = i_a - i_b;
         ALU_AND:  o_result = i_a & i_b;
         ALU_OR:   o_result = i_a | i_b;
         ALU_SLT:  o_result = {31'b0, $signed(i_a) < $signed(i_b)};
         ALU_SLTU: o_result = {31'b0, i_a < i_b};
         default:  o_result = i_a + i_b;
      endcase
   end

   assign o_zero = (o_result == 32'h0);

endmodule

// File: rtl/ex_mem_stage.sv
// MIPS execute stage with MEM/WB forwarding and the negedge EX/MEM pipeline register.
module ex_mem_stage
   import ex_mem_stage_pkg::*;
(
   input  logic          Clk,
   input  logic          Clr,
   ex_mem_stage_if.slave io_bus
);

   ex_mem_t     r_q;
   ex_mem_t     w_d;
   logic [31:0] w_imm32;
   logic [31:0] w_sext;
   logic [31:0] w_fwd_a;
   logic [31:0] w_fwd_b;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_out;
   logic        w_zero;
   alu_ctrl_e   w_ctrl;

   assign w_sext  = {{16{io_bus.EX_immd[15]}}, io_bus.EX_immd};
   assign w_imm32 = io_bus.EX_ExtOp ? w_sext : {16'h0, io_bus.EX_immd};

   // MEM-stage result wins over WB; register 0 is never forwarded.
   always_comb begin
      w_fwd_a = io_bus.EX_busA;
      w_fwd_b = io_bus.EX_busB;
      if (r_q.reg_wr && r_q.rw != 5'd0 && r_q.rw == io_bus.EX_Rs)
         w_fwd_a = r_q.alu_out;
      else if (io_bus.WB_RegWr && io_bus.WB_Rw != 5'd0 && io_bus.WB_Rw == io_bus.EX_Rs)
         w_fwd_a = io_bus.WB_busW;
      if (r_q.reg_wr && r_q.rw != 5'd0 && r_q.rw == io_bus.EX_Rt)
         w_fwd_b = r_q.alu_out;
      else if (io_bus.WB_RegWr && io_bus.WB_Rw != 5'd0 && io_bus.WB_Rw == io_bus.EX_Rt)
         w_fwd_b = io_bus.WB_busW;
   end

   assign w_alu_b = io_bus.EX_ALUSrc ? w_imm32 : w_fwd_b;
   assign w_ctrl  = alu_decode(io_bus.EX_R_type, io_bus.EX_func, io_bus.EX_ALUop);

   ex_mem_stage_alu u_alu (
      .i_a      (w_fwd_a),
      .i_b      (w_alu_b),
      .i_ctrl   (w_ctrl),
      .o_result (w_alu_out),
      .o_zero   (w_zero)
   );

   always_comb begin
      w_d            = '0;
      w_d.pc4        = io_bus.EX_PC4;
      w_d.jtarg      = io_bus.EX_Jtarg;
      w_d.btarg      = io_bus.EX_PC4 + {w_sext[29:0], 2'b00};
      w_d.alu_out    = w_alu_out;
      w_d.bus_b      = w_fwd_b;
      w_d.rw         = io_bus.EX_RegDst ? io_bus.EX_Rd : io_bus.EX_Rt;
      w_d.zero       = w_zero;
      w_d.reg_wr     = io_bus.EX_RegWr;
      w_d.mem_to_reg = io_bus.EX_MemtoReg;
      w_d.mem_wr     = io_bus.EX_MemWr;
      w_d.branch     = io_bus.EX_Branch;
      w_d.jump       = io_bus.EX_Jump;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(negedge Clk or posedge Clr) begin
      if (Clr)
         r_q <= '0;
      else if (io_bus.MEM_PCSrc)
         r_q <= '0;
      else
         r_q <= w_d;
   end

   assign io_bus.MEM_PC4      = r_q.pc4;
   assign io_bus.MEM_Jtarg    = r_q.jtarg;
   assign io_bus.MEM_Btarg    = r_q.btarg;
   assign io_bus.MEM_ALUout   = r_q.alu_out;
   assign io_bus.MEM_busB     = r_q.bus_b;
   assign io_bus.MEM_Rw       = r_q.rw;
   assign io_bus.MEM_Zero     = r_q.zero;
   assign io_bus.MEM_RegWr    = r_q.reg_wr;
   assign io_bus.MEM_MemtoReg = r_q.mem_to_reg;
   assign io_bus.MEM_MemWr    = r_q.mem_wr;
   assign io_bus.MEM_Branch   = r_q.branch;
   assign io_bus.MEM_Jump     = r_q.jump;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table plus hand sequences for forwarding,
// flush and asynchronous reset.
module tb_ex_mem_stage;

   logic clk;
   logic clr;
   int   n_pass  = 0;
   int   n_total = 0;

   ex_mem_stage_if bus();

   ex_mem_stage dut (
      .Clk    (clk),
      .Clr    (clr),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl = {RegWr, MemtoReg, MemWr, Branch, Jump}
   typedef struct {
      string       name;
      logic [31:0] pc4, jtarg, busa, busb;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  func;
      logic [15:0] immd;
      logic [2:0]  aluop;
      logic        r_type, alusrc, regdst, extop;
      logic [4:0]  ctl;
      logic        wb_regwr;
      logic [4:0]  wb_rw;
      logic [31:0] wb_busw;
      logic [31:0] exp_alu, exp_btarg, exp_busb;
      logic        exp_zero;
      logic [4:0]  exp_rw;
   } vec_t;

   function automatic vec_t blank(input string n);
      vec_t v;
      v.name = n;
      v.pc4 = '0; v.jtarg = '0; v.busa = '0; v.busb = '0;
      v.rs = '0; v.rt = '0; v.rd = '0; v.func = '0; v.immd = '0; v.aluop = '0;
      v.r_type = 1'b0; v.alusrc = 1'b0; v.regdst = 1'b0; v.extop = 1'b0;
      v.ctl = '0; v.wb_regwr = 1'b0; v.wb_rw = '0; v.wb_busw = '0;
      v.exp_alu = '0; v.exp_btarg = '0; v.exp_busb = '0; v.exp_zero = 1'b0; v.exp_rw = '0;
      return v;
   endfunction

   function automatic vec_t rv(input string n, input logic [5:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] ea, input logic ez);
      vec_t v;
      v = blank(n);
      v.r_type = 1'b1; v.func = f; v.busa = a; v.busb = b; v.rd = rd; v.regdst = 1'b1;
      v.ctl = 5'b10000; v.pc4 = 32'h400; v.jtarg = 32'h0040_0000;
      v.exp_alu = ea; v.exp_zero = ez; v.exp_rw = rd; v.exp_busb = b; v.exp_btarg = 32'h400;
      return v;
   endfunction

   function automatic vec_t iv(input string n, input logic [2:0] op, input logic ext,
                               input logic [15:0] imm, input logic [31:0] a,
                               input logic [31:0] ea, input logic ez,
                               input logic [31:0] pc, input logic [31:0] eb);
      vec_t v;
      v = blank(n);
      v.aluop = op; v.extop = ext; v.immd = imm; v.busa = a; v.alusrc = 1'b1;
      v.rt = 5'd9; v.busb = 32'h1234; v.ctl = 5'b01000; v.pc4 = pc; v.jtarg = 32'hABCD_0000;
      v.exp_alu = ea; v.exp_zero = ez; v.exp_rw = 5'd9; v.exp_busb = 32'h1234; v.exp_btarg = eb;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input vec_t v, input logic pcsrc);
      bus.EX_PC4 = v.pc4;       bus.EX_Jtarg = v.jtarg;
      bus.EX_busA = v.busa;     bus.EX_busB = v.busb;
      bus.EX_Rs = v.rs;         bus.EX_Rt = v.rt;         bus.EX_Rd = v.rd;
      bus.EX_func = v.func;     bus.EX_immd = v.immd;     bus.EX_ALUop = v.aluop;
      bus.EX_R_type = v.r_type; bus.EX_ALUSrc = v.alusrc;
      bus.EX_RegDst = v.regdst; bus.EX_ExtOp = v.extop;
      bus.EX_RegWr = v.ctl[4];  bus.EX_MemtoReg = v.ctl[3]; bus.EX_MemWr = v.ctl[2];
      bus.EX_Branch = v.ctl[1]; bus.EX_Jump = v.ctl[0];
      bus.WB_RegWr = v.wb_regwr; bus.WB_Rw = v.wb_rw;     bus.WB_busW = v.wb_busw;
      bus.MEM_PCSrc = pcsrc;
   endtask

   task automatic apply(input vec_t v, input logic pcsrc);
      @(posedge clk);
      drive(v, pcsrc);
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] ctl_out();
      return {27'b0, bus.MEM_RegWr, bus.MEM_MemtoReg, bus.MEM_MemWr, bus.MEM_Branch, bus.MEM_Jump};
   endfunction

   task automatic check_vec(input vec_t v);
      check({v.name, ".alu"},   bus.MEM_ALUout, v.exp_alu);
      check({v.name, ".zero"},  {31'b0, bus.MEM_Zero}, {31'b0, v.exp_zero});
      check({v.name, ".rw"},    {27'b0, bus.MEM_Rw}, {27'b0, v.exp_rw});
      check({v.name, ".btarg"}, bus.MEM_Btarg, v.exp_btarg);
      check({v.name, ".busb"},  bus.MEM_busB, v.exp_busb);
      check({v.name, ".ctl"},   ctl_out(), {27'b0, v.ctl});
      check({v.name, ".pc4"},   bus.MEM_PC4, v.pc4);
      check({v.name, ".jtarg"}, bus.MEM_Jtarg, v.jtarg);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".alu"},   bus.MEM_ALUout, 32'h0);
      check({tag, ".btarg"}, bus.MEM_Btarg, 32'h0);
      check({tag, ".pc4"},   bus.MEM_PC4, 32'h0);
      check({tag, ".jtarg"}, bus.MEM_Jtarg, 32'h0);
      check({tag, ".busb"},  bus.MEM_busB, 32'h0);
      check({tag, ".rw_zero_ctl"}, {26'b0, bus.MEM_Rw, bus.MEM_Zero} | ctl_out(), 32'h0);
   endtask

   vec_t tbl [14];
   vec_t v;

   initial begin
      tbl[0]  = rv("r_add",   6'b100000, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0);
      tbl[1]  = rv("r_sub",   6'b100010, 32'd7, 32'd7, 5'd4, 32'd0, 1'b1);
      tbl[2]  = rv("r_and",   6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5, 32'hF000_F000, 1'b0);
      tbl[3]  = rv("r_or",    6'b100101, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd6, 32'hFFFF_F0F0, 1'b0);
      tbl[4]  = rv("r_slt",   6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd1, 1'b0);
      tbl[5]  = rv("r_sltu",  6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd0, 1'b1);
      tbl[6]  = rv("r_deflt", 6'b000000, 32'd3, 32'd4, 5'd10, 32'd7, 1'b0);
      tbl[7]  = rv("r_wrap",  6'b100000, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'd0, 1'b1);
      tbl[8]  = iv("i_ori",   3'b010, 1'b0, 16'h8000, 32'h0, 32'h0000_8000, 1'b0, 32'h1000, 32'hFFFE_1000);
      tbl[9]  = iv("i_slt",   3'b100, 1'b1, 16'hFFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 32'h200, 32'h1FC);
      tbl[10] = iv("i_op111", 3'b111, 1'b0, 16'h0005, 32'd10, 32'd15, 1'b0, 32'h0, 32'h14);
      tbl[11] = iv("i_and",   3'b011, 1'b1, 16'h00FF, 32'hFFFF_1234, 32'h34, 1'b0, 32'h10, 32'h40C);
      tbl[12] = iv("i_sub",   3'b001, 1'b0, 16'h0005, 32'd3, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h14);
      tbl[13] = iv("i_addsx", 3'b000, 1'b1, 16'h8000, 32'h0, 32'hFFFF_8000, 1'b0, 32'h0, 32'hFFFE_0000);

      // Reset asserted with live inputs: outputs must be zero now and across a negedge.
      clr = 1'b1;
      drive(tbl[0], 1'b0);
      #1;
      check_zero("rst_async");
      @(negedge clk);
      #1;
      check_zero("rst_hold");
      @(posedge clk);
      clr = 1'b0;

      for (int i = 0; i < 14; i++) begin
         apply(tbl[i], 1'b0);
         check_vec(tbl[i]);
      end

      // beq with Rs forwarded from the instruction just ahead in MEM.
      v = rv("fwd_src", 6'b100000, 32'd4, 32'd5, 5'd2, 32'd9, 1'b0);
      apply(v, 1'b0);
      check("fwd_src.alu", bus.MEM_ALUout, 32'd9);
      v = blank("beq");
      v.pc4 = 32'h100; v.immd = 16'hFFFF; v.rs = 5'd2; v.busa = 32'd0; v.busb = 32'd9;
      v.aluop = 3'b001; v.ctl = 5'b00010;
      apply(v, 1'b0);
      check("beq.zero", {31'b0, bus.MEM_Zero}, 32'd1);
      check("beq.alu", bus.MEM_ALUout, 32'd0);
      check("beq.btarg", bus.MEM_Btarg, 32'hFC);
      check("beq.ctl", ctl_out(), 32'b00010);

      // MEM beats WB for the same source register.
      v = rv("mem_r4", 6'b100000, 32'd1, 32'd0, 5'd4, 32'd1, 1'b0);
      apply(v, 1'b0);
      v = blank("prio");
      v.r_type = 1'b1; v.func = 6'b100000; v.rs = 5'd4; v.busa = 32'h55;
      v.wb_regwr = 1'b1; v.wb_rw = 5'd4; v.wb_busw = 32'd2;
      apply(v, 1'b0);
      check("prio.alu", bus.MEM_ALUout, 32'd1);
      apply(v, 1'b0);
      check("wb_only.alu", bus.MEM_ALUout, 32'd2);

      // Register 0 is never forwarded from either stage.
      v = rv("w_r0", 6'b100000, 32'h70, 32'd7, 5'd0, 32'h77, 1'b0);
      apply(v, 1'b0);
      check("w_r0.alu", bus.MEM_ALUout, 32'h77);
      v = blank("r0");
      v.r_type = 1'b1; v.func = 6'b100000; v.busa = 32'h30; v.busb = 32'd3;
      v.wb_regwr = 1'b1; v.wb_rw = 5'd0; v.wb_busw = 32'h999;
      apply(v, 1'b0);
      check("r0.alu", bus.MEM_ALUout, 32'h33);

      // sw: address from sign-extended offset, store data forwarded from WB.
      v = blank("sw");
      v.rs = 5'd1; v.busa = 32'h20; v.rt = 5'd6; v.busb = 32'h1111;
      v.extop = 1'b1; v.alusrc = 1'b1; v.immd = 16'hFFFC; v.ctl = 5'b00100;
      v.wb_regwr = 1'b1; v.wb_rw = 5'd6; v.wb_busw = 32'hDEAD;
      apply(v, 1'b0);
      check("sw.alu", bus.MEM_ALUout, 32'h1C);
      check("sw.busb", bus.MEM_busB, 32'hDEAD);
      check("sw.ctl", ctl_out(), 32'b00100);
      check("sw.rw", {27'b0, bus.MEM_Rw}, 32'd6);

      // Flush turns a live instruction into a NOP, then capture resumes.
      v = rv("flush", 6'b100000, 32'd1, 32'd2, 5'd3, 32'd3, 1'b0);
      v.ctl = 5'b11111;
      apply(v, 1'b1);
      check_zero("flush");
      v = rv("resume", 6'b100000, 32'd1, 32'd2, 5'd3, 32'd3, 1'b0);
      apply(v, 1'b0);
      check("resume.alu", bus.MEM_ALUout, 32'd3);

      // Clr between edges clears at once; Clr with PCSrc stays zero; then capture resumes.
      #2;
      clr = 1'b1;
      #1;
      check_zero("clr_mid");
      apply(v, 1'b1);
      check_zero("clr_pcsrc");
      @(posedge clk);
      clr = 1'b0;
      v = rv("after_clr", 6'b100000, 32'd6, 32'd7, 5'd12, 32'd13, 1'b0);
      apply(v, 1'b0);
      check_vec(v);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
